issue_stage: RTL

- Decode/issue stage directly upstream of the 16-bit ALU.
- Decodes one 16-bit instruction, reads operands from an internal 8x16 register file, and sign-extends the immediate.
- Presents registered in1/in2/imm/alu_op/immCalc to the ALU, and accepts the ALU result back through a write-back port.
- A per-register busy scoreboard stalls issue on RAW and WAW hazards.

---
 rtl/issue_stage_pkg.sv | 33 +++
 rtl/issue_regfile.sv | 49 ++++
 rtl/issue_stage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/issue_stage_pkg.sv
// Shared definitions for the issue stage: instruction field layout, ALU opcodes
// and datapath defaults.
package issue_stage_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int NREG_DEF   = 8;
  localparam int IMM_W_DEF  = 6;
  localparam int REG_AW     = 3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_MUL = 3'd2;
  localparam logic [2:0] ALU_DIV = 3'd3;
  localparam logic [2:0] ALU_SHL = 3'd4;
  localparam logic [2:0] ALU_SHR = 3'd5;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int I_BIT  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM_LO = 0;

  // Opcodes above SHR (110, 111) are unassigned.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= ALU_SHR);
  endfunction

endpackage

// File: rtl/issue_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, r0 hardwired to zero, synchronous active-high clear.
module issue_regfile
  import issue_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_AW-1:0]        raddr1,
  input  logic [REG_AW-1:0]        raddr2,
  output logic signed [DATA_W-1:0] rdata1,
  output logic signed [DATA_W-1:0] rdata2,
  input  logic                     we,
  input  logic [REG_AW-1:0]        waddr,
  input  logic signed [DATA_W-1:0] wdata
);

  logic signed [DATA_W-1:0] mem_q [NREG];
  logic signed [DATA_W-1:0] mem_d [NREG];

  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we && (waddr != '0)) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/issue_stage.sv
// Decode/issue stage in front of the 16-bit ALU with a busy-bit scoreboard.
// Optional same-cycle write-back forwarding is enabled by defining WB_BYPASS_EN.
module issue_stage
  import issue_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int IMM_W  = IMM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] in2,
  output logic [DATA_W-1:0] imm,
  output logic [2:0]        alu_op,
  output logic              immCalc,
  output logic [2:0]        out_rd,
  output logic              illegal,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] f);
    return {{(DATA_W-IMM_W){f[IMM_W-1]}}, f};
  endfunction

  logic [2:0]               op;
  logic                     imm_sel;
  logic [REG_AW-1:0]        rd;
  logic [REG_AW-1:0]        rs1;
  logic [REG_AW-1:0]        rs2;
  logic signed [DATA_W-1:0] imm_ext;
  logic signed [DATA_W-1:0] rf_rd1;
  logic signed [DATA_W-1:0] rf_rd2;
  logic signed [DATA_W-1:0] src1;
  logic signed [DATA_W-1:0] src2;
  logic [NREG-1:0]          busy_eff;
  logic                     wb_hit;
  logic                     fwd1;
  logic                     fwd2;
  logic                     hazard;
  logic                     accept;
  logic                     legal;

  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] in1_q, in1_d;
  logic signed [DATA_W-1:0] in2_q, in2_d;
  logic signed [DATA_W-1:0] imm_q, imm_d;
  logic [2:0]               alu_op_q, alu_op_d;
  logic                     imm_calc_q, imm_calc_d;
  logic [2:0]               out_rd_q, out_rd_d;
  logic                     illegal_q, illegal_d;
  logic [NREG-1:0]          busy_q, busy_d;

  issue_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  // Decode and hazard detection
  always_comb begin
    op      = instr[OP_HI:OP_LO];
    imm_sel = instr[I_BIT];
    rd      = instr[RD_HI:RD_LO];
    rs1     = instr[RS1_HI:RS1_LO];
    rs2     = instr[RS2_HI:RS2_LO];
    imm_ext = sext_imm(instr[IMM_LO +: IMM_W]);
    legal   = is_legal_op(op);

    busy_eff    = busy_q;
    busy_eff[0] = 1'b0;
    wb_hit      = wb_en && (wb_addr != '0);

`ifdef WB_BYPASS_EN
    fwd1 = wb_hit && (wb_addr == rs1);
    fwd2 = wb_hit && (wb_addr == rs2);
`else
    fwd1 = 1'b0;
    fwd2 = 1'b0;
`endif

    // WAW is never forwarded: the new owner must wait for the old one to retire.
    hazard = (busy_eff[rs1] && !fwd1)
          || (!imm_sel && busy_eff[rs2] && !fwd2)
          || busy_eff[rd];

    in_ready = !rst && !hazard && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;

    src1 = fwd1 ? $signed(wb_data) : rf_rd1;
    src2 = fwd2 ? $signed(wb_data) : rf_rd2;
  end

  // Output register and scoreboard next state
  always_comb begin
    out_valid_d = out_valid_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    imm_d       = imm_q;
    alu_op_d    = alu_op_q;
    imm_calc_d  = imm_calc_q;
    out_rd_d    = out_rd_q;
    illegal_d   = 1'b0;
    busy_d      = busy_q;

    if (accept && legal) begin
      out_valid_d = 1'b1;
      in1_d       = src1;
      in2_d       = imm_sel ? '0 : src2;
      imm_d       = imm_sel ? imm_ext : '0;
      alu_op_d    = op;
      imm_calc_d  = imm_sel;
      out_rd_d    = rd;
    end else if (accept) begin
      out_valid_d = 1'b0;
      illegal_d   = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear before set so a same-edge issue to the retiring register keeps it busy.
    if (wb_hit) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (accept && legal && (rd != '0)) begin
      busy_d[rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Issue register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
      imm_q       <= '0;
      alu_op_q    <= '0;
      imm_calc_q  <= 1'b0;
      out_rd_q    <= '0;
      illegal_q   <= 1'b0;
      busy_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      imm_q       <= imm_d;
      alu_op_q    <= alu_op_d;
      imm_calc_q  <= imm_calc_d;
      out_rd_q    <= out_rd_d;
      illegal_q   <= illegal_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign in1       = in1_q;
  assign in2       = in2_q;
  assign imm       = imm_q;
  assign alu_op    = alu_op_q;
  assign immCalc   = imm_calc_q;
  assign out_rd    = out_rd_q;
  assign illegal   = illegal_q;

endmodule
